// File: rtl/regfile_pkg.sv
// Shared constants and the writeback request bundle for the register-file controller.
package regfile_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int DW    = 64;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  // Round-robin pointer encoding: names the side that wins a tie.
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic [DW-1:0]    dat;
  } wb_req_t;

endpackage

// File: rtl/regfile_ctrl_dec5to32.sv
// 5-bit register number to 32-bit one-hot select; purely combinational.
module dec5to32
  import regfile_pkg::*;
(
  input  logic [REG_W-1:0] i_sel,
  output logic [NREG-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Read-select decode, busy-bit hazard scoreboard and round-robin write-port arbiter.
// Writeback commits one edge after an uncontested request; issue stalls on RAW/WAW.
module regfile_ctrl
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_ra,
  input  logic [REG_W-1:0] issue_rb,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_rd_we,
  output logic             issue_ready,
  output logic [NREG-1:0]  Aselect,
  output logic [NREG-1:0]  Bselect,
  input  logic             alu_wb_valid,
  input  logic [REG_W-1:0] alu_wb_rd,
  input  logic [DW-1:0]    alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             mem_wb_valid,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic [DW-1:0]    mem_wb_data,
  output logic             mem_wb_ready,
  output logic [NREG-1:0]  Dselect,
  output logic [DW-1:0]    dbus,
  output logic             wb_err,
  output logic [31:0]      stall_cnt
);

  logic [NREG-2:0] r_busy;
  logic            r_rr;
  logic [NREG-1:0] r_dselect;
  logic [DW-1:0]   r_dbus;
  logic            r_wb_err;
  logic [31:0]     r_stall_cnt;

  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [NREG-1:0] w_dsel_dec;
  logic            w_issue_ready;
  logic            w_issue_set;
  logic            w_stall;
  logic            w_gnt_alu;
  logic            w_gnt_mem;
  logic            w_gnt;
  logic            w_wb_real;
  logic            w_wb_err_set;
  wb_req_t         w_alu_req;
  wb_req_t         w_mem_req;
  wb_req_t         w_win;

  assign w_busy = {1'b0, r_busy};

  dec5to32 u_dec_a (.i_sel(issue_ra),  .o_onehot(Aselect));
  dec5to32 u_dec_b (.i_sel(issue_rb),  .o_onehot(Bselect));
  dec5to32 u_dec_d (.i_sel(w_win.rd),  .o_onehot(w_dsel_dec));

  // Hazard check sees registered busy bits only; a same-cycle writeback does not bypass.
  assign w_issue_ready = ~reset & ~(w_busy[issue_ra] | w_busy[issue_rb] |
                                    (issue_rd_we & w_busy[issue_rd]));
  assign w_issue_set   = issue_valid & w_issue_ready & issue_rd_we & (issue_rd != ZERO_REG);
  assign w_stall       = issue_valid & ~w_issue_ready;

  assign w_alu_req = '{vld: alu_wb_valid, rd: alu_wb_rd, dat: alu_wb_data};
  assign w_mem_req = '{vld: mem_wb_valid, rd: mem_wb_rd, dat: mem_wb_data};

  assign w_gnt_mem = ~reset & w_mem_req.vld & (~w_alu_req.vld | (r_rr == WB_MEM));
  assign w_gnt_alu = ~reset & w_alu_req.vld & ~w_gnt_mem;
  assign w_gnt     = w_gnt_alu | w_gnt_mem;
  assign w_win     = w_gnt_mem ? w_mem_req : w_alu_req;

  assign w_wb_real    = w_gnt & (w_win.rd != ZERO_REG);
  assign w_wb_err_set = w_wb_real & ~w_busy[w_win.rd];

  // Clear before set so an illegal same-register collision leaves the bit busy.
  always_comb begin
    w_busy_nxt = w_busy;
    if (w_wb_real)   w_busy_nxt[w_win.rd] = 1'b0;
    if (w_issue_set) w_busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      r_rr        <= WB_ALU;
      r_dselect   <= '0;
      r_dbus      <= '0;
      r_wb_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt[NREG-2:0];
      if (w_gnt) begin
        r_rr      <= w_gnt_alu ? WB_MEM : WB_ALU;
        r_dbus    <= w_win.dat;
        r_dselect <= w_wb_real ? w_dsel_dec : '0;
      end else begin
        r_dselect <= '0;
      end
      if (w_wb_err_set) r_wb_err <= 1'b1;
      if (w_stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign issue_ready  = w_issue_ready;
  assign alu_wb_ready = w_gnt_alu;
  assign mem_wb_ready = w_gnt_mem;
  assign Dselect      = r_dselect;
  assign dbus         = r_dbus;
  assign wb_err       = r_wb_err;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed scenarios plus randomized traffic checked against a set-based scoreboard model.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_ra, issue_rb, issue_rd;
  logic        issue_rd_we;
  logic        issue_ready;
  logic [31:0] Aselect, Bselect;
  logic        alu_wb_valid, mem_wb_valid;
  logic [4:0]  alu_wb_rd, mem_wb_rd;
  logic [63:0] alu_wb_data, mem_wb_data;
  logic        alu_wb_ready, mem_wb_ready;
  logic [31:0] Dselect;
  logic [63:0] dbus;
  logic        wb_err;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
    .Aselect(Aselect), .Bselect(Bselect),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .Dselect(Dselect), .dbus(dbus), .wb_err(wb_err), .stall_cnt(stall_cnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: set of pending destinations, last committed write, counters.
  bit [31:0] m_busy;
  bit        m_prefer_mem;
  bit [31:0] m_dsel;
  bit [63:0] m_dbus;
  bit        m_err;
  bit [31:0] m_stall;

  bit        s_rst, s_iv, s_we, s_av, s_mv;
  bit [4:0]  s_ra, s_rb, s_rd, s_ard, s_mrd;
  bit [63:0] s_adat, s_mdat;

  task automatic idle();
    s_rst = 0; s_iv = 0; s_ra = 0; s_rb = 0; s_rd = 0; s_we = 0;
    s_av = 0; s_ard = 0; s_adat = 0; s_mv = 0; s_mrd = 0; s_mdat = 0;
  endtask

  task automatic set_issue(input bit [4:0] ra, input bit [4:0] rb, input bit [4:0] rd, input bit we);
    s_iv = 1; s_ra = ra; s_rb = rb; s_rd = rd; s_we = we;
  endtask

  task automatic set_alu(input bit [4:0] rd, input bit [63:0] d);
    s_av = 1; s_ard = rd; s_adat = d;
  endtask

  task automatic set_mem(input bit [4:0] rd, input bit [63:0] d);
    s_mv = 1; s_mrd = rd; s_mdat = d;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // One clock: apply staged inputs, check every output, then advance the model.
  task automatic cycle();
    bit        exp_rdy, ga, gm;
    bit [4:0]  wrd;
    @(negedge clk);
    reset = s_rst; issue_valid = s_iv; issue_ra = s_ra; issue_rb = s_rb;
    issue_rd = s_rd; issue_rd_we = s_we;
    alu_wb_valid = s_av; alu_wb_rd = s_ard; alu_wb_data = s_adat;
    mem_wb_valid = s_mv; mem_wb_rd = s_mrd; mem_wb_data = s_mdat;
    #1;
    exp_rdy = !s_rst && !(m_busy[s_ra] || m_busy[s_rb] || (s_we && m_busy[s_rd]));
    ga = 0; gm = 0;
    if (!s_rst) begin
      if (s_av && s_mv) begin
        gm = m_prefer_mem;
        ga = !m_prefer_mem;
      end else begin
        ga = s_av;
        gm = s_mv;
      end
    end
    chk("issue_ready", issue_ready, exp_rdy);
    chk("alu_wb_ready", alu_wb_ready, ga);
    chk("mem_wb_ready", mem_wb_ready, gm);
    chk("Aselect", Aselect, 32'd1 << s_ra);
    chk("Bselect", Bselect, 32'd1 << s_rb);
    chk("Dselect", Dselect, m_dsel);
    chk("dbus", dbus, m_dbus);
    chk("wb_err", wb_err, m_err);
    chk("stall_cnt", stall_cnt, m_stall);
    if (s_rst) begin
      m_busy = 0; m_prefer_mem = 0; m_dsel = 0; m_dbus = 0; m_err = 0; m_stall = 0;
    end else begin
      if (s_iv && !exp_rdy) m_stall = m_stall + 1;
      if (ga || gm) begin
        wrd    = gm ? s_mrd : s_ard;
        m_dbus = gm ? s_mdat : s_adat;
        m_dsel = (wrd == 31) ? 32'd0 : (32'd1 << wrd);
        if (wrd != 31) begin
          if (!m_busy[wrd]) m_err = 1;
          m_busy[wrd] = 0;
        end
        m_prefer_mem = ga;
      end else begin
        m_dsel = 0;
      end
      if (s_iv && exp_rdy && s_we && s_rd != 31) m_busy[s_rd] = 1;
    end
  endtask

  function automatic bit [4:0] pick_rd();
    bit [4:0] q[$];
    for (int r = 0; r < 31; r++) if (m_busy[r]) q.push_back(5'(r));
    if (q.size() == 0 || $urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  initial begin
    reset = 1; issue_valid = 0; issue_ra = 0; issue_rb = 0; issue_rd = 0; issue_rd_we = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    m_busy = 0; m_prefer_mem = 0; m_dsel = 0; m_dbus = 0; m_err = 0; m_stall = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a write in flight when reset asserts
    idle(); s_rst = 1; cycle();
    idle(); set_issue(0, 0, 5, 1); cycle();
    idle(); set_alu(5, 64'hDEAD); cycle(); settle();
    chk("mid_dsel_pre", Dselect, 32'h20);
    idle(); set_issue(0, 0, 5, 1); cycle();
    idle(); s_rst = 1; set_alu(5, 64'hDEAD); cycle();
    chk("mid_rdy_in_rst", issue_ready, 0);
    settle();
    chk("mid_dsel_post", Dselect, 0);
    chk("mid_err", wb_err, 0);
    idle(); set_issue(5, 5, 5, 1); cycle();
    chk("mid_busy_clr", issue_ready, 1);

    // RAW stall
    idle(); s_rst = 1; cycle();
    idle(); set_issue(0, 0, 3, 1); cycle();
    idle(); set_issue(3, 0, 0, 0); cycle();
    set_alu(3, 64'h1234); cycle();
    chk("raw_stall_rdy", issue_ready, 0);
    settle();
    chk("raw_dsel", Dselect, 32'h8);
    chk("raw_dbus", dbus, 64'h1234);
    s_av = 0; cycle();
    chk("raw_go_rdy", issue_ready, 1);
    settle();
    chk("raw_stall_cnt", stall_cnt, 2);

    // Contention round-robin
    idle(); s_rst = 1; cycle();
    idle(); set_issue(0, 0, 1, 1); cycle();
    set_issue(0, 0, 2, 1); cycle();
    idle(); set_alu(1, 64'h11); set_mem(2, 64'h22); cycle(); settle();
    chk("rr_first_dsel", Dselect, 32'h2);
    chk("rr_first_dbus", dbus, 64'h11);
    cycle(); settle();
    chk("rr_second_dsel", Dselect, 32'h4);
    chk("rr_second_dbus", dbus, 64'h22);
    chk("rr_err", wb_err, 0);

    // R31 handling
    idle(); set_issue(0, 0, 31, 1); cycle();
    set_issue(31, 31, 31, 1); cycle();
    chk("r31_never_busy", issue_ready, 1);
    idle(); set_mem(31, 64'hFF); cycle();
    chk("r31_mem_rdy", mem_wb_ready, 1);
    settle();
    chk("r31_dsel", Dselect, 0);
    chk("r31_err", wb_err, 0);

    // WAW stall
    idle(); set_issue(0, 0, 7, 1); cycle();
    cycle();
    chk("waw_stall", issue_ready, 0);
    set_alu(7, 64'h77); cycle();
    chk("waw_stall_wb", issue_ready, 0);
    s_av = 0; cycle();
    chk("waw_go", issue_ready, 1);
    idle(); set_alu(7, 64'h78); cycle();

    // Protocol error: write to a register nobody is waiting on
    idle(); set_alu(9, 64'h99); cycle(); settle();
    chk("perr_dsel", Dselect, 32'h200);
    chk("perr_set", wb_err, 1);
    idle(); repeat (3) cycle();
    chk("perr_sticky", wb_err, 1);
    s_rst = 1; cycle(); settle();
    chk("perr_rst", wb_err, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 199) == 0);
      s_iv   = ($urandom_range(0, 3) != 0);
      s_ra   = 5'($urandom_range(0, 31));
      s_rb   = 5'($urandom_range(0, 31));
      s_rd   = 5'($urandom_range(0, 31));
      s_we   = ($urandom_range(0, 1) == 1);
      s_av   = ($urandom_range(0, 2) == 0);
      s_ard  = pick_rd();
      s_adat = {$urandom, $urandom};
      s_mv   = ($urandom_range(0, 2) == 0);
      s_mrd  = pick_rd();
      s_mdat = {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
